// File: rtl/sub_float64_pkg.sv
// Shared types, constants and helpers for the float64 same-sign significand subtractor.
package sub_float64_pkg;

    localparam int unsigned SIG_W  = 64;
    localparam int unsigned EXP_W  = 11;
    localparam int unsigned ZEXP_W = 13;
    localparam int unsigned KEY_W  = 22;

    localparam logic [SIG_W-1:0] DEFAULT_NAN = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [SIG_W-1:0] QNAN_BIT    = 64'h0008_0000_0000_0000;
    localparam logic [SIG_W-1:0] HIDDEN_BIT  = 64'h4000_0000_0000_0000;
    localparam logic [9:0]       ROUND_INC   = 10'h200;
    localparam logic [EXP_W-1:0] EXP_MAX     = 11'h7FF;

    localparam int unsigned KEY_NO_JAM = 5;
    localparam int unsigned KEY_TRUNC  = 6;
    localparam int unsigned KEY_NO_INV = 7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ALIGN,
        S_SUB,
        S_NORM,
        S_DONE
    } state_t;

    // Aligned operands (or a resolved special result) handed from S_ALIGN to S_SUB.
    typedef struct packed {
        logic             special;
        logic [SIG_W-1:0] spec_res;
        logic             b_larger;
        logic [EXP_W-1:0] exp_big;
        logic [SIG_W-1:0] sig_big;
        logic [SIG_W-1:0] sig_small;
    } align_t;

    // Logical right shift; any bit shifted out sets bit 0 unless jamming is disabled.
    function automatic logic [SIG_W-1:0] shift_right_jam(input logic [SIG_W-1:0] v,
                                                         input logic [ZEXP_W-1:0] cnt,
                                                         input logic jam_en);
        logic [SIG_W-1:0] mask;
        logic [SIG_W-1:0] r;
        mask = '0;
        r    = v;
        if (cnt == 13'd0) begin
            r = v;
        end else if (cnt < 13'd64) begin
            mask = (64'h1 << cnt[5:0]) - 64'h1;
            r    = (v >> cnt[5:0]) | {63'b0, jam_en & (|(v & mask))};
        end else begin
            r = {63'b0, jam_en & (|v)};
        end
        return r;
    endfunction

endpackage

// File: rtl/float64_norm_round_pack.sv
// Normalise, subnormal jam, round-to-nearest-even and pack of a float64 difference.
module float64_norm_round_pack
    import sub_float64_pkg::*;
(
    input  logic                     z_sign,
    input  logic signed [ZEXP_W-1:0] z_exp,
    input  logic [SIG_W-1:0]         z_sig,
    input  logic                     jam_en,
    input  logic                     trunc,
    output logic [SIG_W-1:0]         result_c
);

    function automatic logic [6:0] clz64(input logic [SIG_W-1:0] v);
        logic [6:0] n;
        logic       found;
        n     = 7'd64;
        found = 1'b0;
        for (int i = 63; i >= 0; i--) begin
            if (!found && v[i]) begin
                n     = 7'(63 - i);
                found = 1'b1;
            end
        end
        return n;
    endfunction

    logic [6:0]               lz;
    logic [5:0]               sh;
    logic [SIG_W-1:0]         sig_n;
    logic [SIG_W-1:0]         sig_r;
    logic [SIG_W-1:0]         sum;
    logic signed [ZEXP_W-1:0] exp_n;
    logic [EXP_W-1:0]         exp_r;
    logic [9:0]               round_bits;
    logic [53:0]              z;

    always_comb begin
        lz    = clz64(z_sig);
        sh    = (lz == 7'd0) ? 6'd0 : 6'(lz - 7'd1);
        sig_n = z_sig << sh;
        exp_n = z_exp - $signed({7'b0, sh});
        sig_r = sig_n;
        exp_r = exp_n[EXP_W-1:0];
        // Negative exponent: denormalise into the subnormal range.
        if (exp_n[ZEXP_W-1]) begin
            sig_r = shift_right_jam(sig_n, 13'(-exp_n), jam_en);
            exp_r = '0;
        end
        round_bits = sig_r[9:0];
        sum        = sig_r + (trunc ? 64'h0 : {54'b0, ROUND_INC});
        z          = sum[SIG_W-1:10];
        if (!trunc && (round_bits == ROUND_INC)) begin
            z[0] = 1'b0;
        end
        if (z == '0) begin
            exp_r = '0;
        end
        // A carry out of z deliberately bumps the exponent field.
        result_c = {z_sign, 63'b0} + {1'b0, exp_r, 52'b0} + {10'b0, z};
    end

endmodule

// File: rtl/sub_float64_sigs_core.sv
// ap_ctrl_hs callee: same-sign float64 significand subtraction with fixed 4-cycle latency.
module sub_float64_sigs_core
    import sub_float64_pkg::*;
(
    input  logic             ap_clk,
    input  logic             ap_rst,
    input  logic             ap_start,
    output logic             ap_done,
    output logic             ap_idle,
    output logic             ap_ready,
    input  logic [SIG_W-1:0] a,
    input  logic [SIG_W-1:0] b,
    input  logic             zSign,
    output logic [SIG_W-1:0] ap_return,
    input  logic [KEY_W-1:0] working_key
);

    state_t state_q;
    state_t state_d;

    logic [SIG_W-1:0]         op_a_q;
    logic [SIG_W-1:0]         op_b_q;
    logic                     op_sign_q;
    align_t                   al_c;
    align_t                   al_q;
    logic [SIG_W-1:0]         z_sig_q;
    logic signed [ZEXP_W-1:0] z_exp_q;
    logic                     z_sign_q;
    logic [SIG_W-1:0]         npr_c;

    logic                     jam_en;
    logic                     trunc;
    logic                     no_inv;
    logic                     unused_key;

    assign jam_en     = ~working_key[KEY_NO_JAM];
    assign trunc      = working_key[KEY_TRUNC];
    assign no_inv     = working_key[KEY_NO_INV];
    assign unused_key = ^{working_key[KEY_W-1:8], working_key[4:0]};
    assign ap_ready   = ap_done;

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (ap_start) state_d = S_ALIGN;
            S_ALIGN: state_d = S_SUB;
            S_SUB:   state_d = S_NORM;
            S_NORM:  state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and handshake/result registers.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q   <= S_IDLE;
            ap_done   <= 1'b0;
            ap_idle   <= 1'b1;
            ap_return <= '0;
        end else begin
            state_q <= state_d;
            ap_done <= (state_d == S_DONE);
            ap_idle <= (state_d == S_IDLE);
            if (state_q == S_NORM) begin
                ap_return <= al_q.special ? al_q.spec_res : npr_c;
            end
        end
    end

    logic [EXP_W-1:0]       a_exp;
    logic [EXP_W-1:0]       b_exp;
    logic [SIG_W-1:0]       a_sig;
    logic [SIG_W-1:0]       b_sig;
    logic signed [11:0]     exp_diff;
    logic [11:0]            diff_mag;
    logic                   a_nan;
    logic                   b_nan;

    // Operand unpack, special-case resolution and exponent alignment.
    always_comb begin
        a_exp    = op_a_q[62:52];
        b_exp    = op_b_q[62:52];
        a_sig    = {2'b00, op_a_q[51:0], 10'b0};
        b_sig    = {2'b00, op_b_q[51:0], 10'b0};
        exp_diff = 12'(a_exp) - 12'(b_exp);
        diff_mag = exp_diff[11] ? 12'(-exp_diff) : 12'(exp_diff);
        a_nan    = (a_exp == EXP_MAX) && (op_a_q[51:0] != '0);
        b_nan    = (b_exp == EXP_MAX) && (op_b_q[51:0] != '0);
        al_c     = '0;
        if (a_nan || b_nan) begin
            al_c.special  = 1'b1;
            al_c.spec_res = (b_nan ? op_b_q : op_a_q) | QNAN_BIT;
        end else if (!exp_diff[11] && (exp_diff != 12'sd0)) begin
            if (a_exp == EXP_MAX) begin
                al_c.special  = 1'b1;
                al_c.spec_res = op_a_q;
            end else begin
                al_c.exp_big   = a_exp;
                al_c.sig_big   = a_sig | HIDDEN_BIT;
                al_c.sig_small = (b_exp == '0)
                               ? shift_right_jam(b_sig, 13'(diff_mag - 12'd1), jam_en)
                               : shift_right_jam(b_sig | HIDDEN_BIT, 13'(diff_mag), jam_en);
            end
        end else if (exp_diff[11]) begin
            if (b_exp == EXP_MAX) begin
                al_c.special  = 1'b1;
                al_c.spec_res = {~op_sign_q, EXP_MAX, 52'b0};
            end else begin
                al_c.b_larger  = 1'b1;
                al_c.exp_big   = b_exp;
                al_c.sig_big   = b_sig | HIDDEN_BIT;
                al_c.sig_small = (a_exp == '0)
                               ? shift_right_jam(a_sig, 13'(diff_mag - 12'd1), jam_en)
                               : shift_right_jam(a_sig | HIDDEN_BIT, 13'(diff_mag), jam_en);
            end
        end else begin
            // Equal exponents: hidden bits cancel, so only raw fractions are compared.
            if (a_exp == EXP_MAX) begin
                al_c.special  = 1'b1;
                al_c.spec_res = DEFAULT_NAN;
            end else begin
                al_c.exp_big = (a_exp == '0) ? 11'd1 : a_exp;
                if (b_sig < a_sig) begin
                    al_c.sig_big   = a_sig;
                    al_c.sig_small = b_sig;
                end else if (a_sig < b_sig) begin
                    al_c.b_larger  = 1'b1;
                    al_c.sig_big   = b_sig;
                    al_c.sig_small = a_sig;
                end else begin
                    al_c.special  = 1'b1;
                    al_c.spec_res = '0;
                end
            end
        end
    end

    // Datapath stage registers, each loaded in its own FSM state.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            op_a_q    <= '0;
            op_b_q    <= '0;
            op_sign_q <= 1'b0;
            al_q      <= '0;
            z_sig_q   <= '0;
            z_exp_q   <= '0;
            z_sign_q  <= 1'b0;
        end else begin
            if ((state_q == S_IDLE) && ap_start) begin
                op_a_q    <= a;
                op_b_q    <= b;
                op_sign_q <= zSign;
            end
            if (state_q == S_ALIGN) begin
                al_q <= al_c;
            end
            if (state_q == S_SUB) begin
                z_sig_q  <= al_q.sig_big - al_q.sig_small;
                z_exp_q  <= $signed({2'b00, al_q.exp_big}) - 13'sd1;
                z_sign_q <= op_sign_q ^ (al_q.b_larger & ~no_inv);
            end
        end
    end

    float64_norm_round_pack u_norm_round_pack (
        .z_sign   (z_sign_q),
        .z_exp    (z_exp_q),
        .z_sig    (z_sig_q),
        .jam_en   (jam_en),
        .trunc    (trunc),
        .result_c (npr_c)
    );

endmodule
